// File: rtl/bcd_display_driver_pkg.sv
// Shared types and constants for the serial binary-to-BCD three-digit display driver.
// Holds the FSM encoding, the active-low segment patterns and the add-3 digit correction.
package bcd_display_driver_pkg;

   localparam int BCD_DIGITS = 3;
   localparam int BCD_W      = BCD_DIGITS * 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Segment order is a..g on bits [0:6]; a cleared bit lights the segment.
   localparam logic [0:6] SEG_0     = 7'b0000001;
   localparam logic [0:6] SEG_1     = 7'b1001111;
   localparam logic [0:6] SEG_2     = 7'b0010010;
   localparam logic [0:6] SEG_3     = 7'b0000110;
   localparam logic [0:6] SEG_4     = 7'b1001100;
   localparam logic [0:6] SEG_5     = 7'b0100100;
   localparam logic [0:6] SEG_6     = 7'b0100000;
   localparam logic [0:6] SEG_7     = 7'b0001111;
   localparam logic [0:6] SEG_8     = 7'b0000000;
   localparam logic [0:6] SEG_9     = 7'b0000100;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;

   // Double-dabble correction: any nibble of 5 or more gets +3 before the next shift.
   function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (res[i*4 +: 4] >= 4'd5) begin
            res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
         end else begin
            res[i*4 +: 4] = res[i*4 +: 4];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_display_driver_seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern, with a forced-blank input.
// Non-decimal nibbles also show blank.
module seg7_decoder
   import bcd_display_driver_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [0:6] seg
);

   // Pattern lookup; blank overrides the digit
   always_comb begin
      seg = SEG_BLANK;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_driver.sv
// Serial shift-and-add-3 binary-to-BCD converter driving three 7-segment digits.
// Displays update only on the commit cycle, so intermediate scratch values never show.
module bcd_display_driver
   import bcd_display_driver_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int AUTO        = 1,
   parameter int BLANK_ZEROS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] value_in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [0:6]       display_unidad,
   output logic [0:6]       display_decena,
   output logic [0:6]       display_centena
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [0:6] SEG_LEAD_RST = (BLANK_ZEROS != 0) ? SEG_BLANK : SEG_0;

   state_t             state_r;
   logic [WIDTH-1:0]   shift_r;
   logic [WIDTH-1:0]   last_r;
   logic [BCD_W-1:0]   scratch_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [BCD_W-1:0]   adj_s;
   logic               trigger_s;
   logic               blank_h_s;
   logic               blank_t_s;
   logic [0:6]         seg_u_s;
   logic [0:6]         seg_t_s;
   logic [0:6]         seg_h_s;

   // Conversion request: explicit start, or a changed input when auto mode is on
   always_comb begin
      trigger_s = 1'b0;
      if (start) begin
         trigger_s = 1'b1;
      end else if ((AUTO != 0) && (value_in != last_r)) begin
         trigger_s = 1'b1;
      end else begin
         trigger_s = 1'b0;
      end
   end

   // Scratch correction ahead of the shift, and leading-zero blanking of the result
   always_comb begin
      adj_s     = bcd_adjust(scratch_r);
      blank_h_s = (BLANK_ZEROS != 0) && (scratch_r[11:8] == 4'd0);
      blank_t_s = blank_h_s && (scratch_r[7:4] == 4'd0);
   end

   seg7_decoder u_dec_unidad (
      .digit (scratch_r[3:0]),
      .blank (1'b0),
      .seg   (seg_u_s)
   );

   seg7_decoder u_dec_decena (
      .digit (scratch_r[7:4]),
      .blank (blank_t_s),
      .seg   (seg_t_s)
   );

   seg7_decoder u_dec_centena (
      .digit (scratch_r[11:8]),
      .blank (blank_h_s),
      .seg   (seg_h_s)
   );

   // Conversion FSM with registered status and display outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r         <= ST_IDLE;
         shift_r         <= {WIDTH{1'b0}};
         last_r          <= {WIDTH{1'b0}};
         scratch_r       <= {BCD_W{1'b0}};
         cnt_r           <= {CNT_W{1'b0}};
         busy            <= 1'b0;
         done            <= 1'b0;
         display_unidad  <= SEG_0;
         display_decena  <= SEG_LEAD_RST;
         display_centena <= SEG_LEAD_RST;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (trigger_s) begin
                  shift_r   <= value_in;
                  last_r    <= value_in;
                  scratch_r <= {BCD_W{1'b0}};
                  cnt_r     <= CNT_W'(WIDTH);
                  busy      <= 1'b1;
                  state_r   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               scratch_r <= {adj_s[BCD_W-2:0], shift_r[WIDTH-1]};
               shift_r   <= shift_r << 1;
               cnt_r     <= cnt_r - CNT_W'(1);
               // busy drops as the last bit shifts in, so it spans exactly WIDTH cycles
               if (cnt_r == CNT_W'(1)) begin
                  busy    <= 1'b0;
                  state_r <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               display_unidad  <= seg_u_s;
               display_decena  <= seg_t_s;
               display_centena <= seg_h_s;
               done            <= 1'b1;
               busy            <= 1'b0;
               state_r         <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: decimal-arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed segment patterns and latencies.
module tb_bcd_display_driver;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic [W-1:0] value_in;
   logic         start;
   logic         busy;
   logic         done;
   logic [0:6]   display_unidad;
   logic [0:6]   display_decena;
   logic [0:6]   display_centena;

   int total = 0;
   int bad   = 0;

   bcd_display_driver #(.WIDTH(W), .AUTO(1), .BLANK_ZEROS(1)) dut (
      .clk             (clk),
      .rst             (rst),
      .value_in        (value_in),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .display_unidad  (display_unidad),
      .display_decena  (display_decena),
      .display_centena (display_centena)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [0:6] seg_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   localparam logic [0:6] BLK = 7'b1111111;

   // pos 0 = units, 1 = tens, 2 = hundreds
   function automatic logic [0:6] exp_seg(input int v, input int pos);
      int h, t, u;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      if (pos == 0) return seg_tbl[u];
      if (pos == 1) return (h == 0 && t == 0) ? BLK : seg_tbl[t];
      return (h == 0) ? BLK : seg_tbl[h];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: value shown, and when a captured value must appear
   int  cyc = 0;
   bit  model_ok = 1'b0;
   bit  m_act = 1'b0;
   int  m_commit = 0;
   int  m_cap = 0;
   int  m_last = 0;
   int  m_disp = 0;
   bit  e_busy = 1'b0;
   bit  e_done = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         m_act    = 1'b0;
         m_last   = 0;
         m_disp   = 0;
         e_busy   = 1'b0;
         e_done   = 1'b0;
         model_ok = 1'b1;
      end else begin
         e_done = 1'b0;
         if (m_act) begin
            if (cyc == m_commit) begin
               m_disp = m_cap;
               e_done = 1'b1;
               m_act  = 1'b0;
            end
         end else if (start || int'(value_in) != m_last) begin
            m_act    = 1'b1;
            m_cap    = int'(value_in);
            m_last   = int'(value_in);
            m_commit = cyc + W + 1;
         end
         e_busy = m_act && (cyc < m_commit - 1);
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         chk("unidad", 32'(display_unidad), 32'(exp_seg(m_disp, 0)));
         chk("decena", 32'(display_decena), 32'(exp_seg(m_disp, 1)));
         chk("centena", 32'(display_centena), 32'(exp_seg(m_disp, 2)));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(output int cycles, output int busy_cycles);
      cycles = 0;
      busy_cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (busy) busy_cycles++;
      end while (!done && cycles < 40);
      if (!done) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected one", cycles);
      end
   endtask

   task automatic chk_disp(input string name, input logic [0:6] u, input logic [0:6] t,
                           input logic [0:6] h);
      chk({name, "_u"}, 32'(display_unidad), 32'(u));
      chk({name, "_t"}, 32'(display_decena), 32'(t));
      chk({name, "_h"}, 32'(display_centena), 32'(h));
   endtask

   int cy, bc;

   initial begin
      rst      = 1'b0;
      value_in = '0;
      start    = 1'b0;
      tick(3);
      rst = 1'b1;
      tick(5);
      chk("rst_busy", 32'(busy), 32'd0);
      chk_disp("rst", 7'b0000001, 7'b1111111, 7'b1111111);

      value_in = 8'd13;
      wait_done(cy, bc);
      chk("lat13", 32'(cy), 32'd10);
      chk("busy13", 32'(bc), 32'd8);
      chk_disp("v13", 7'b0000110, 7'b1001111, 7'b1111111);

      value_in = 8'd255;
      wait_done(cy, bc);
      chk_disp("v255", 7'b0100100, 7'b0100100, 7'b0010010);

      value_in = 8'd105;
      wait_done(cy, bc);
      chk_disp("v105", 7'b0100100, 7'b0000001, 7'b1001111);

      value_in = 8'd7;
      wait_done(cy, bc);
      chk_disp("v7", 7'b0001111, 7'b1111111, 7'b1111111);

      value_in = 8'd42;
      tick(3);
      chk_disp("hold7", 7'b0001111, 7'b1111111, 7'b1111111);
      value_in = 8'd99;
      start    = 1'b1;
      tick(1);
      start    = 1'b0;
      wait_done(cy, bc);
      chk_disp("v42", 7'b0010010, 7'b1001100, 7'b1111111);
      wait_done(cy, bc);
      chk("lat99", 32'(cy), 32'd10);
      chk_disp("v99", 7'b0000100, 7'b0000100, 7'b1111111);

      value_in = 8'd200;
      tick(4);
      rst = 1'b0;
      tick(1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk_disp("abort", 7'b0000001, 7'b1111111, 7'b1111111);
      rst = 1'b1;
      wait_done(cy, bc);
      chk("lat200", 32'(cy), 32'd10);
      chk_disp("v200", 7'b0000001, 7'b0000001, 7'b0010010);

      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_done(cy, bc);
      chk("lat_start", 32'(cy), 32'd9);
      chk_disp("again200", 7'b0000001, 7'b0000001, 7'b0010010);

      value_in = 8'd10;
      wait_done(cy, bc);
      chk_disp("v10", 7'b0000001, 7'b1001111, 7'b1111111);

      value_in = 8'd0;
      wait_done(cy, bc);
      chk_disp("v0", 7'b0000001, 7'b1111111, 7'b1111111);

      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
